// File: rtl/z80_bus_ctrl.sv
// Z80 bus-cycle sequencer: turns single core requests into T-state sequences
// (M1 fetch with refresh, memory and IO read/write) driving registered pad outputs.
module z80_bus_ctrl #(
  parameter int IO_WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  input  logic        halt_in,
  output logic [6:0]  refresh_r,
  output logic [15:0] addr,
  output logic        n_mreq,
  output logic        n_iorq,
  output logic        n_rd,
  output logic        n_wr,
  output logic        n_m1,
  output logic        n_halt,
  output logic [7:0]  data_out,
  output logic        data_out_en,
  input  logic [7:0]  data_in
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4} state_t;

  localparam logic [2:0] TY_FETCH  = 3'd0;
  localparam logic [2:0] TY_MEM_RD = 3'd1;
  localparam logic [2:0] TY_MEM_WR = 3'd2;
  localparam logic [2:0] TY_IO_RD  = 3'd3;
  localparam logic [2:0] TY_IO_WR  = 3'd4;
  localparam logic [1:0] WAIT_LOAD = (IO_WAIT_STATES > 0) ? 2'(IO_WAIT_STATES - 1) : 2'd0;

  state_t      state_reg, state_next;
  logic [2:0]  type_reg;
  logic [15:0] addr_lat_reg;
  logic [7:0]  wdata_reg;
  logic [1:0]  wait_reg, wait_next;

  logic        accept;
  logic [2:0]  cur_type;
  logic [15:0] cur_addr;
  logic [7:0]  cur_wdata;
  logic        is_fetch, is_write, is_io, is_read, is_reserved;

  logic        rsp_valid_next;
  logic [7:0]  rsp_rdata_next;
  logic [6:0]  refresh_next;
  logic [15:0] addr_next;
  logic [7:0]  data_out_next;
  logic        data_out_en_next;
  logic        n_mreq_next, n_iorq_next, n_rd_next, n_wr_next, n_m1_next;

  assign req_ready = (state_reg == S_IDLE);
  assign accept    = req_valid && req_ready;

  // The cycle being started uses the live request; later cycles use the latched copy.
  assign cur_type    = accept ? req_type  : type_reg;
  assign cur_addr    = accept ? req_addr  : addr_lat_reg;
  assign cur_wdata   = accept ? req_wdata : wdata_reg;
  assign is_fetch    = (cur_type == TY_FETCH);
  assign is_write    = (cur_type == TY_MEM_WR) || (cur_type == TY_IO_WR);
  assign is_io       = (cur_type == TY_IO_RD)  || (cur_type == TY_IO_WR);
  assign is_read     = (cur_type == TY_FETCH) || (cur_type == TY_MEM_RD) || (cur_type == TY_IO_RD);
  assign is_reserved = (cur_type > TY_IO_WR);

  always_comb begin
    state_next     = state_reg;
    wait_next      = wait_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata;
    refresh_next   = refresh_r;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (is_reserved) begin
            rsp_valid_next = 1'b1;
            rsp_rdata_next = 8'hFF;
          end else begin
            state_next = S_T1;
          end
        end
      end
      S_T1: state_next = S_T2;
      S_T2: begin
        if (is_io && (IO_WAIT_STATES > 0)) begin
          state_next = S_TW;
          wait_next  = WAIT_LOAD;
        end else begin
          state_next = S_T3;
        end
      end
      S_TW: begin
        if (wait_reg == 2'd0) state_next = S_T3;
        else                  wait_next  = wait_reg - 2'd1;
      end
      S_T3: begin
        if (is_fetch) begin
          state_next = S_T4;
        end else begin
          state_next     = S_IDLE;
          rsp_valid_next = 1'b1;
        end
      end
      S_T4: begin
        state_next     = S_IDLE;
        rsp_valid_next = 1'b1;
        refresh_next   = refresh_r + 7'd1;
      end
      default: state_next = S_IDLE;
    endcase

    // Read data is sampled on the edge that leaves the last T2/TW state.
    if ((state_next == S_T3) && ((state_reg == S_T2) || (state_reg == S_TW)) && is_read)
      rsp_rdata_next = data_in;

    // Pad outputs are decoded from the state being entered, so they line up with it.
    addr_next        = addr;
    data_out_next    = data_out;
    data_out_en_next = 1'b0;
    n_mreq_next      = 1'b1;
    n_iorq_next      = 1'b1;
    n_rd_next        = 1'b1;
    n_wr_next        = 1'b1;
    n_m1_next        = 1'b1;
    case (state_next)
      S_T1, S_T2, S_TW: begin
        if (state_next == S_T1) begin
          addr_next = cur_addr;
          if (is_write) data_out_next = cur_wdata;
        end
        data_out_en_next = is_write;
        case (cur_type)
          TY_FETCH: begin
            n_m1_next   = 1'b0;
            n_mreq_next = 1'b0;
            n_rd_next   = 1'b0;
          end
          TY_MEM_RD: begin
            n_mreq_next = 1'b0;
            n_rd_next   = 1'b0;
          end
          TY_MEM_WR: begin
            n_mreq_next = 1'b0;
            n_wr_next   = (state_next == S_T1);
          end
          TY_IO_RD: begin
            n_iorq_next = (state_next == S_T1);
            n_rd_next   = (state_next == S_T1);
          end
          TY_IO_WR: begin
            n_iorq_next = (state_next == S_T1);
            n_wr_next   = (state_next == S_T1);
          end
          default: ;
        endcase
      end
      S_T3: begin
        data_out_en_next = is_write;
        if (is_fetch) begin
          n_mreq_next = 1'b0;
          addr_next   = {9'b0, refresh_r};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      type_reg     <= '0;
      addr_lat_reg <= '0;
      wdata_reg    <= '0;
      wait_reg     <= '0;
      addr         <= '0;
      data_out     <= '0;
      data_out_en  <= 1'b0;
      n_mreq       <= 1'b1;
      n_iorq       <= 1'b1;
      n_rd         <= 1'b1;
      n_wr         <= 1'b1;
      n_m1         <= 1'b1;
      n_halt       <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'hFF;
      refresh_r    <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (accept) begin
        type_reg     <= req_type;
        addr_lat_reg <= req_addr;
        wdata_reg    <= req_wdata;
      end
      addr        <= addr_next;
      data_out    <= data_out_next;
      data_out_en <= data_out_en_next;
      n_mreq      <= n_mreq_next;
      n_iorq      <= n_iorq_next;
      n_rd        <= n_rd_next;
      n_wr        <= n_wr_next;
      n_m1        <= n_m1_next;
      n_halt      <= ~halt_in;
      rsp_valid   <= rsp_valid_next;
      rsp_rdata   <= rsp_rdata_next;
      refresh_r   <= refresh_next;
    end
  end

endmodule
